// File: rtl/flopr.sv
// flopr: parameterised D register that captures on rising ph1 with a synchronous, active-high reset.
// ph2 is on the port list only so existing positional instances keep working; nothing reads it.
module flopr #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Deliberately dangling so that ph2 never reaches any logic.
    logic unused_ph2;
    assign unused_ph2 = ph2;

    // Reset wins over d. There is no enable, so every ph1 edge loads something.
    always_comb begin
        q_d = d;
        if (reset) begin
            q_d = RESET_VALUE;
        end
    end

    always_ff @(posedge ph1) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: tb/tb_flopr.sv
// tb_flopr: directed vectors with hand-computed expectations for a 2-bit flopr and a 32-bit flopr.
// ph1 and ph2 are driven by hand so that ph1 can be held low while ph2 is pulsed.
`timescale 1ns/1ps
module tb_flopr;

    logic        ph1;
    logic        ph2;
    logic        reset;
    logic [1:0]  d2;
    logic [1:0]  q2;
    logic [31:0] d32;
    logic [31:0] q32;

    int n_checks = 0;
    int n_errors = 0;

    flopr #(.WIDTH(2)) u_flopr2 (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .d     (d2),
        .q     (q2)
    );

    flopr #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u_flopr32 (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .d     (d32),
        .q     (q32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end
    endtask

    // One full ph1 cycle. It finishes with ph1 low, 5 ns after the rising edge.
    task automatic tick();
        #5 ph1 = 1'b1;
        #5 ph1 = 1'b0;
    endtask

    initial begin
        logic [1:0] load_vals [4];
        load_vals[0] = 2'b01;
        load_vals[1] = 2'b10;
        load_vals[2] = 2'b11;
        load_vals[3] = 2'b00;

        ph1   = 1'b0;
        ph2   = 1'b0;
        reset = 1'b1;
        d2    = 2'b11;
        d32   = 32'hFFFF0000;

        // Neither register has been clocked yet, so both must still hold X.
        #2;
        chk("q2_uninit",  {30'd0, q2}, {30'd0, 2'bxx});
        chk("q32_uninit", q32, 32'hxxxxxxxx);

        tick();
        chk("q2_reset",  {30'd0, q2}, 32'h0);
        chk("q32_reset", q32, 32'hDEADBEEF);

        // The first edge after reset is released captures d.
        reset = 1'b0;
        d32   = 32'h12345678;
        foreach (load_vals[i]) begin
            d2 = load_vals[i];
            tick();
            chk($sformatf("q2_load%0d", i), {30'd0, q2}, {30'd0, load_vals[i]});
            d2 = ~load_vals[i];
            #2;
            chk($sformatf("q2_stable%0d", i), {30'd0, q2}, {30'd0, load_vals[i]});
        end
        chk("q32_load", q32, 32'h12345678);

        // Reset on the same edge as d: reset must win, then d loads on the next edge.
        d2    = 2'b10;
        reset = 1'b1;
        tick();
        chk("q2_rst_prio", {30'd0, q2}, 32'h0);
        chk("q32_rst_prio", q32, 32'hDEADBEEF);
        reset = 1'b0;
        tick();
        chk("q2_after_prio", {30'd0, q2}, {30'd0, 2'b10});
        chk("q32_after_prio", q32, 32'h12345678);

        // Pulse ph2 five times with ph1 held low while d and reset move around.
        for (int k = 0; k < 5; k++) begin
            d2    = 2'(k);
            d32   = 32'hA5A50000 + 32'(k);
            reset = k[0];
            #1 ph2 = 1'b1;
            #2 ph2 = 1'b0;
            #1;
        end
        chk("q2_ph2", {30'd0, q2}, {30'd0, 2'b10});
        chk("q32_ph2", q32, 32'h12345678);

        // Hold ph2 high across a ph1 edge. Only d may matter at that edge.
        reset = 1'b0;
        d2    = 2'b01;
        d32   = 32'h0BADF00D;
        ph2   = 1'b1;
        tick();
        ph2   = 1'b0;
        chk("q2_ph2_overlap", {30'd0, q2}, {30'd0, 2'b01});
        chk("q32_ph2_overlap", q32, 32'h0BADF00D);

        // Reset glitch between edges must be invisible at the next edge.
        d2 = 2'b11;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        chk("q2_glitch_mid", {30'd0, q2}, {30'd0, 2'b01});
        tick();
        chk("q2_glitch_edge", {30'd0, q2}, {30'd0, 2'b11});
        chk("q32_glitch_edge", q32, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
